// File: rtl/fb_pkg.sv
// Shared types and constants for the 64x64, 12-bit RGB framebuffer.
package fb_pkg;

   localparam int FB_W     = 64;
   localparam int FB_H     = 64;
   localparam int FB_DEPTH = FB_W * FB_H;

   // One pixel, 4 bits per channel, packed {r, g, b}.
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } pixel_t;

   // Clear-engine control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } fb_state_t;

   // Linear pixel address: y*64 + x.
   function automatic logic [11:0] fb_addr(input logic [5:0] x, input logic [5:0] y);
      return {y, x};
   endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter and its three requesters.
//
// Handshakes:
//  - Display read: i_rd_req is a one-cycle request with no back-pressure; the
//    data comes back on o_rd_data qualified by o_rd_valid exactly two cycles later.
//  - Game write: the pixel transfers on a rising clock edge where
//    i_wr_valid && o_wr_ready. o_wr_ready never looks at i_wr_valid, so a
//    writer may wait for ready before raising valid; once raised, valid and
//    its address/data are held until the transfer happens.
//  - Clear: i_clr_start is a one-cycle pulse, honoured only while idle;
//    i_clr_color is sampled on that same edge.
interface fb_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 12
);
   logic              i_rd_req;
   logic [ADDR_W-1:0] i_rd_addr;
   logic [DATA_W-1:0] o_rd_data;
   logic              o_rd_valid;

   logic              i_wr_valid;
   logic [ADDR_W-1:0] i_wr_addr;
   logic [DATA_W-1:0] i_wr_data;
   logic              o_wr_ready;

   logic              i_clr_start;
   logic [DATA_W-1:0] i_clr_color;
   logic              o_clr_busy;
   logic              o_clr_done;

   // Arbiter side.
   modport slave (
      input  i_rd_req, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data,
             i_clr_start, i_clr_color,
      output o_rd_data, o_rd_valid, o_wr_ready, o_clr_busy, o_clr_done
   );

   // Requester side.
   modport master (
      output i_rd_req, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data,
             i_clr_start, i_clr_color,
      input  o_rd_data, o_rd_valid, o_wr_ready, o_clr_busy, o_clr_done
   );
endinterface

// File: rtl/fb_ram.sv
// Single-port framebuffer RAM: synchronous write, registered read, no reset,
// written so synthesis maps it onto block RAM.
module fb_ram
   import fb_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 12,
   parameter int DEPTH  = FB_DEPTH
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write when enabled; the read register always follows the addressed word.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_addr] <= i_wdata;
      end
      o_rdata <= mem[i_addr];
   end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer owner: arbitrates the single RAM port between display reads
// (highest), the built-in clear engine, and single-pixel game writes (lowest).
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 12
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   fb_arbiter_if.slave bus,
   output fb_state_t o_dbg_state
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

   fb_state_t         state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0] clr_color_q, clr_color_d;

   logic              wr_ready;
   logic              clr_wr;
   logic              game_wr;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic              rd_pend_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;

   // A read owns the port outright; otherwise the clear engine, then the game.
   assign wr_ready = (state_q == IDLE) && !bus.i_rd_req;
   assign clr_wr   = (state_q == CLEAR) && !bus.i_rd_req;
   assign game_wr  = wr_ready && bus.i_wr_valid;

   // Select the single RAM access for this cycle.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = bus.i_rd_addr;
      ram_wdata = bus.i_wr_data;
      if (bus.i_rd_req) begin
         ram_we   = 1'b0;
         ram_addr = bus.i_rd_addr;
      end else if (clr_wr) begin
         ram_we    = 1'b1;
         ram_addr  = clr_cnt_q;
         ram_wdata = clr_color_q;
      end else if (game_wr) begin
         ram_we    = 1'b1;
         ram_addr  = bus.i_wr_addr;
         ram_wdata = bus.i_wr_data;
      end
   end

   // Clear-engine next state, counter and latched colour.
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      clr_color_d = clr_color_q;
      case (state_q)
         IDLE: begin
            if (bus.i_clr_start) begin
               clr_color_d = bus.i_clr_color;
               clr_cnt_d   = '0;
               state_d     = CLEAR;
            end
         end
         CLEAR: begin
            // Stalled by reads; the counter parks on the last address.
            if (clr_wr) begin
               if (clr_cnt_q == LAST_ADDR) begin
                  state_d = DONE;
               end else begin
                  clr_cnt_d = clr_cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Clear-engine state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         clr_cnt_q   <= '0;
         clr_color_q <= '0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         clr_color_q <= clr_color_d;
      end
   end

   // Read-valid pipeline: RAM register at N+1, output register at N+2.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_pend_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_pend_q  <= bus.i_rd_req;
         rd_valid_q <= rd_pend_q;
         if (rd_pend_q) begin
            rd_data_q <= ram_rdata;
         end
      end
   end

   fb_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (FB_DEPTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (ram_we),
      .i_addr  (ram_addr),
      .i_wdata (ram_wdata),
      .o_rdata (ram_rdata)
   );

   assign bus.o_rd_data  = rd_data_q;
   assign bus.o_rd_valid = rd_valid_q;
   assign bus.o_wr_ready = wr_ready;
   assign bus.o_clr_busy = (state_q == CLEAR);
   assign bus.o_clr_done = (state_q == DONE);
   assign o_dbg_state    = state_q;

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Owns the 64x64 framebuffer that holds 12-bit RGB pixels, and shares its single memory port between three requesters. The display pipeline reads with fixed latency and top priority. A built-in clear engine fills the whole buffer with one colour. The game logic writes single pixels through a valid/ready handshake. The block sits between `game` (writer) and the VGA pixel fetch in `graphics_top`, and replaces the three separate per-channel colour arrays.

## Interface
- `ADDR_W`, default 12: pixel address width, covering 4096 pixels (addr = y*64 + x).
- `DATA_W`, default 12: pixel width, packed {r[3:0], g[3:0], b[3:0]}.
- `i_clk` input 1: single system clock (100 MHz). Display reads arrive at the pixel-enable rate.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_rd_req` input 1: display read request this cycle.
- `i_rd_addr` input ADDR_W: display read address.
- `o_rd_data` output DATA_W: read pixel.
- `o_rd_valid` output 1: `o_rd_data` is valid this cycle.
- `i_wr_valid` input 1: game write request.
- `i_wr_addr` input ADDR_W: game write address.
- `i_wr_data` input DATA_W: game write pixel.
- `o_wr_ready` output 1: a game write is accepted this cycle when valid && ready.
- `i_clr_start` input 1: one-cycle pulse that starts a full-buffer clear.
- `i_clr_color` input DATA_W: fill colour. Sampled on an accepted start.
- `o_clr_busy` output 1: clear in progress.
- `o_clr_done` output 1: one-cycle pulse when the clear completes.

## Operation
- The memory port serves exactly one access per cycle. Priority order: display read, then clear write, then game write.
- FSM states:
  - IDLE:
    - `i_clr_start` latches `i_clr_color`, zeroes the clear counter and moves to CLEAR.
    - Starts are ignored in CLEAR.
  - CLEAR:
    - In each cycle without `i_rd_req`, writes the latched colour at the counter address and increments the counter.
    - The write at address 4095 moves the FSM to DONE.
  - DONE: asserts `o_clr_done` for one cycle, then returns to IDLE.
- `o_wr_ready` = (state == IDLE) && !`i_rd_req`. It is combinational and does not depend on `i_wr_valid`.
- An accepted game write updates memory at that clock edge.
- Start and write in the same IDLE cycle: the write is accepted if ready, and the clear begins the next cycle, so the clear overwrites the written pixel.
- A read never observes a same-cycle write, because reads and writes are mutually exclusive.
- The clear counter is ADDR_W bits and does not wrap. It stops at 4095.
- `o_clr_busy` = (state == CLEAR).
- Addresses are unchecked. All 4096 values are legal.

## Timing
- Read latency is 2 cycles:
  - `i_rd_req` at cycle N gives `o_rd_valid` with `o_rd_data` at N+2.
  - The path is RAM registered read at N+1, then the output register.
  - Back-to-back reads are fully pipelined.
- Clear duration is 4096 plus (read cycles during CLEAR) cycles from start acceptance to DONE. `o_clr_done` asserts the cycle after the final write.
- Reset values:
  - state = IDLE, clear counter = 0.
  - `o_rd_valid` = 0, `o_rd_data` = 0.
  - `o_clr_busy` = 0, `o_clr_done` = 0.
  - `o_wr_ready` follows the IDLE equation immediately.
- Reset in mid-operation:
  - During CLEAR it aborts the clear with no `o_clr_done`.
  - In-flight reads are dropped (`o_rd_valid` = 0).
  - Memory contents are not reset, so partial clear data remains.
- Pixel-rate reads (1 in 4 cycles) leave 3 of every 4 slots for clear and writes.

## Structure
- Package `fb_pkg`:
  - `FB_W` = 64, `FB_H` = 64, `FB_DEPTH` = 4096.
  - `pixel_t` packed struct {r, g, b} of 4-bit fields.
  - `fb_state_t` enum {IDLE, CLEAR, DONE}.
  - Helper function `fb_addr(x, y)`.
- Sub-module `fb_ram`: single-port 4096 x DATA_W synchronous RAM with write enable and registered read, no reset, block-RAM inferable.
- The arbiter mux, FSM, counter and read-valid pipeline live in `fb_arbiter`.

## Test plan
- **Write then read:** write 0xF00 at addr 65 with `i_rd_req` low, so ready = 1. Then read addr 65. Expect `o_rd_valid` with 0xF00 exactly 2 cycles after the request.
- **Read blocks write:** hold `i_wr_valid` with 0x0F0 at addr 10 while `i_rd_req` = 1 for 5 cycles. Expect `o_wr_ready` = 0 for those cycles, and the write accepted in the first cycle after `i_rd_req` drops.
- **Clear without reads:** start with colour 0x00F. Expect `o_clr_busy` high for 4096 cycles and a single `o_clr_done` pulse. A readback of addresses 0, 2047 and 4095 returns 0x00F. `o_wr_ready` is 0 throughout.
- **Clear interleaved with reads:** run the clear with `i_rd_req` asserted 1 cycle in 4. Expect completion after 4096 + (read count) cycles, all reads returning on time, and no address skipped.
- **Start during CLEAR, start plus write:**
  - A second start during CLEAR is ignored, and the colour stays at its first value.
  - A start and a write to addr 5 in the same IDLE cycle: addr 5 ends holding the clear colour.
- **Reset mid-clear:** assert `i_rst_n` low at clear counter 1000. Expect all outputs at their reset values, no `o_clr_done`, and addr 999 holding the clear colour. A new start is then accepted.
